// File: rtl/serial_pattern_feeder.sv
// rtl/serial_pattern_feeder.sv - MSB-first serial stimulus shifter with per-bit hold and strobe.
// Optional SERIAL_FEEDER_LOOP_EN: repeat frames back-to-back from the shadow register.
module serial_pattern_feeder #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [WIDTH-1:0]           din,
  input  logic                       start,
  output logic                       w,
  output logic                       bit_tick,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] bits_left
);

  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BLW = $clog2(WIDTH + 1);
  localparam logic [PW-1:0]  PRE_MAX = PW'(DIV - 1);
  localparam logic [BLW-1:0] BL_FULL = BLW'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_shift;
  logic [PW-1:0]    r_pre;
  logic [BLW-1:0]   r_bits_left;
  logic             r_w;
  logic             r_busy;
  logic             r_done;

  logic             w_tick;
  logic             w_last;
  logic [WIDTH-1:0] w_pattern;
  logic [WIDTH-1:0] w_shift_nxt;

  assign w_tick      = (r_state == SHIFT) && (r_pre == PRE_MAX);
  assign w_last      = w_tick && (r_bits_left == BLW'(1));
  // A load on the same edge as start bypasses the shadow so the new word goes out at once.
  assign w_pattern   = load ? din : r_shadow;
  assign w_shift_nxt = r_shift << 1;

  assign w         = r_w;
  assign bit_tick  = w_tick;
  assign busy      = r_busy;
  assign done      = r_done;
  assign bits_left = r_bits_left;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (start) w_state_nxt = SHIFT;
`ifdef SERIAL_FEEDER_LOOP_EN
      SHIFT: if (start) w_state_nxt = IDLE;
`else
      SHIFT: if (w_last) w_state_nxt = DONE;
`endif
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow    <= '0;
      r_shift     <= '0;
      r_pre       <= '0;
      r_bits_left <= '0;
      r_w         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load) r_shadow <= din;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift     <= w_pattern;
            r_bits_left <= BL_FULL;
            r_pre       <= '0;
            r_busy      <= 1'b1;
            r_w         <= w_pattern[WIDTH-1];
          end
        end
        SHIFT: begin
`ifdef SERIAL_FEEDER_LOOP_EN
          if (start) begin
            r_pre       <= '0;
            r_bits_left <= '0;
            r_w         <= 1'b0;
            r_busy      <= 1'b0;
          end else
`endif
          if (w_tick) begin
            r_pre <= '0;
            if (w_last) begin
              r_done <= 1'b1;
`ifdef SERIAL_FEEDER_LOOP_EN
              // Reload from shadow so loads made during the frame take effect without a gap.
              r_shift     <= r_shadow;
              r_bits_left <= BL_FULL;
              r_w         <= r_shadow[WIDTH-1];
`else
              r_shift     <= w_shift_nxt;
              r_bits_left <= '0;
              r_w         <= 1'b0;
              r_busy      <= 1'b0;
`endif
            end else begin
              r_shift     <= w_shift_nxt;
              r_bits_left <= r_bits_left - BLW'(1);
              r_w         <= w_shift_nxt[WIDTH-1];
            end
          end else begin
            r_pre <= r_pre + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_feeder.sv
// tb/tb_serial_pattern_feeder.sv - directed self-checking bench for serial_pattern_feeder.
module tb_serial_pattern_feeder;

  logic       clk = 1'b0;
  logic       reset, load, start;
  logic [7:0] din;
  logic       w, bit_tick, busy, done;
  logic [3:0] bits_left;

  logic       b_reset, b_load, b_start;
  logic [3:0] b_din;
  logic       b_w, b_bit_tick, b_busy, b_done;
  logic [2:0] b_bits_left;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_pattern_feeder #(.WIDTH(8), .DIV(4)) u_dut (
    .clk(clk), .reset(reset), .load(load), .din(din), .start(start),
    .w(w), .bit_tick(bit_tick), .busy(busy), .done(done), .bits_left(bits_left)
  );

  serial_pattern_feeder #(.WIDTH(4), .DIV(1)) u_b (
    .clk(clk), .reset(b_reset), .load(b_load), .din(b_din), .start(b_start),
    .w(b_w), .bit_tick(b_bit_tick), .busy(b_busy), .done(b_done), .bits_left(b_bits_left)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered one step after the start edge E0; checks the 32 busy cycles and the done cycle.
  task automatic check_frame(input logic [7:0] pat, input int st_at, input int ld_at,
                             input logic [7:0] ld_val);
    for (int c = 0; c < 32; c++) begin
      int b;
      b = c / 4;
      check("frame_w", {31'd0, w}, {31'd0, pat[7-b]});
      check("frame_busy", {31'd0, busy}, 32'd1);
      check("frame_tick", {31'd0, bit_tick}, {31'd0, (c % 4) == 3});
      check("frame_bits_left", {28'd0, bits_left}, 32'(8 - b));
      check("frame_done", {31'd0, done}, 32'd0);
      if (c == st_at) start = 1'b1;
      if (c == ld_at) begin
        load = 1'b1;
        din  = ld_val;
      end
      tick();
      start = 1'b0;
      load  = 1'b0;
    end
    check("end_done", {31'd0, done}, 32'd1);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_w", {31'd0, w}, 32'd0);
    check("end_bits_left", {28'd0, bits_left}, 32'd0);
    check("end_tick", {31'd0, bit_tick}, 32'd0);
    tick();
    check("after_done", {31'd0, done}, 32'd0);
    check("after_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [3:0] bpat;
    reset = 1'b1; load = 1'b0; start = 1'b0; din = 8'h00;
    b_reset = 1'b1; b_load = 1'b0; b_start = 1'b0; b_din = 4'h0;
    tick();
    tick();
    check("rst_w", {31'd0, w}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_tick", {31'd0, bit_tick}, 32'd0);
    check("rst_bits_left", {28'd0, bits_left}, 32'd0);
    reset = 1'b0;
    b_reset = 1'b0;
    tick();

    // Basic frame: load then start.
    din = 8'h33; load = 1'b1;
    tick();
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check_frame(8'h33, -1, -1, 8'h00);

    // Bypass: load and start together, then shadow replay.
    din = 8'hA5; load = 1'b1; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    check_frame(8'hA5, -1, -1, 8'h00);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_frame(8'hA5, -1, -1, 8'h00);

    // Start and load during SHIFT do not disturb the frame in flight.
    din = 8'h0F; load = 1'b1; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    check_frame(8'h0F, 8, 20, 8'hF0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_frame(8'hF0, -1, -1, 8'h00);

    // Asynchronous reset in bit 3 of an F0 frame.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 15; c++) tick();
    check("pre_rst_w", {31'd0, w}, 32'd1);
    check("pre_rst_tick", {31'd0, bit_tick}, 32'd1);
    check("pre_rst_bits_left", {28'd0, bits_left}, 32'd5);
    #2 reset = 1'b1;
    #1;
    check("arst_w", {31'd0, w}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_tick", {31'd0, bit_tick}, 32'd0);
    check("arst_bits_left", {28'd0, bits_left}, 32'd0);
    tick();
    check("arst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("post_rst_done", {31'd0, done}, 32'd0);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check_frame(8'h00, -1, -1, 8'h00);

    // DIV=1, WIDTH=4 boundary.
    bpat = 4'b1011;
    b_din = bpat; b_load = 1'b1; b_start = 1'b1;
    tick();
    b_load = 1'b0; b_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("b_w", {31'd0, b_w}, {31'd0, bpat[3-c]});
      check("b_tick", {31'd0, b_bit_tick}, 32'd1);
      check("b_busy", {31'd0, b_busy}, 32'd1);
      check("b_bits_left", {29'd0, b_bits_left}, 32'(4 - c));
      check("b_done_low", {31'd0, b_done}, 32'd0);
      tick();
    end
    check("b_done", {31'd0, b_done}, 32'd1);
    check("b_end_tick", {31'd0, b_bit_tick}, 32'd0);
    check("b_end_busy", {31'd0, b_busy}, 32'd0);
    tick();
    check("b_after_done", {31'd0, b_done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
